// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-channel button synchronizer, debounce counter and edge pulses
module button_debounce #(
  parameter int   N_BTN           = 3,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   CNT_W           = 19,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_rel,
  output logic             btn_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]            sync1, sync2;
  logic [N_BTN-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [N_BTN-1:0]            clean_nxt, press_nxt, rel_nxt;
  logic                        any_nxt;

  // Raw pins are asynchronous; only sync2 may be used past this point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {N_BTN{RESET_LEVEL}};
      sync2 <= {N_BTN{RESET_LEVEL}};
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    cnt_nxt   = '0;
    clean_nxt = btn_clean;
    press_nxt = '0;
    rel_nxt   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != btn_clean[i]) begin
        if (cnt[i] == CNT_MAX) begin
          // Qualified: commit the new level and flag its direction on the same edge.
          clean_nxt[i] = sync2[i];
          press_nxt[i] = (sync2[i] != RESET_LEVEL);
          rel_nxt[i]   = (sync2[i] == RESET_LEVEL);
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
    any_nxt = |(press_nxt | rel_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      btn_clean <= {N_BTN{RESET_LEVEL}};
      btn_press <= '0;
      btn_rel   <= '0;
      btn_any   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      btn_clean <= clean_nxt;
      btn_press <= press_nxt;
      btn_rel   <= rel_nxt;
      btn_any   <= any_nxt;
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed-vector self-checking bench for button_debounce
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_clean, btn_press, btn_rel;
  logic       btn_any;

  int compared   = 0;
  int mismatched = 0;

  button_debounce #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .CNT_W(3), .RESET_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_clean(btn_clean), .btn_press(btn_press), .btn_rel(btn_rel), .btn_any(btn_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] raw;
    logic [2:0] clean;
    logic [2:0] press;
    logic [2:0] rel;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  task automatic add_n(input int n, input logic r, input logic [2:0] raw,
                       input logic [2:0] clean, input logic [2:0] press,
                       input logic [2:0] rel, input logic any);
    vec_t v;
    v.rst = r; v.raw = raw; v.clean = clean; v.press = press; v.rel = rel; v.any = any;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] clean, input logic [2:0] press,
                       input logic [2:0] rel, input logic any);
    compared++;
    if (btn_clean !== clean || btn_press !== press || btn_rel !== rel || btn_any !== any) begin
      mismatched++;
      $display("FAIL %s: got clean=%b press=%b rel=%b any=%b, expected clean=%b press=%b rel=%b any=%b",
               name, btn_clean, btn_press, btn_rel, btn_any, clean, press, rel, any);
    end
  endtask

  task automatic cycle(input logic r, input logic [2:0] raw);
    @(negedge clk);
    rst = r;
    btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic pat [6];
    logic [2:0] ec, ep, er;
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with all keys held, then qualify to all-pressed on edge 6.
    add_n(2, 1'b1, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
    add_n(5, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
    add_n(1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 1'b1);
    add_n(2, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    // Release all keys together.
    add_n(5, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
    add_n(1, 1'b0, 3'b111, 3'b111, 3'b000, 3'b111, 1'b1);
    add_n(2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0);
    // Single key press and release on channel 0.
    add_n(5, 1'b0, 3'b110, 3'b111, 3'b000, 3'b000, 1'b0);
    add_n(1, 1'b0, 3'b110, 3'b110, 3'b001, 3'b000, 1'b1);
    add_n(2, 1'b0, 3'b110, 3'b110, 3'b000, 3'b000, 1'b0);
    add_n(5, 1'b0, 3'b111, 3'b110, 3'b000, 3'b000, 1'b0);
    add_n(1, 1'b0, 3'b111, 3'b111, 3'b000, 3'b001, 1'b1);
    add_n(2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0);
    // Channel 1 glitches of 3 cycles never qualify.
    for (int r = 0; r < 5; r++) begin
      add_n(3, 1'b0, 3'b101, 3'b111, 3'b000, 3'b000, 1'b0);
      add_n(1, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0);
    end
    add_n(3, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].raw);
      check($sformatf("vec%0d", i), vecs[i].clean, vecs[i].press, vecs[i].rel, vecs[i].any);
    end

    // Staggered presses two cycles apart, then simultaneous release.
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, (k >= 3) ? 3'b010 : 3'b110);
      ec = (k < 6) ? 3'b111 : (k < 8) ? 3'b110 : 3'b010;
      ep = (k == 6) ? 3'b001 : (k == 8) ? 3'b100 : 3'b000;
      check($sformatf("stagger_k%0d", k), ec, ep, 3'b000, (k == 6) || (k == 8));
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 3'b111);
      ec = (k < 6) ? 3'b010 : 3'b111;
      er = (k == 6) ? 3'b101 : 3'b000;
      check($sformatf("simul_rel_k%0d", k), ec, 3'b000, er, k == 6);
    end

    // Reset mid-count discards progress and re-qualifies from the released level.
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 3'b110);
      check($sformatf("premid_k%0d", k), 3'b111, 3'b000, 3'b000, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async", 3'b111, 3'b000, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held", 3'b111, 3'b000, 3'b000, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b0, 3'b110);
      ec = (k < 6) ? 3'b111 : 3'b110;
      ep = (k == 6) ? 3'b001 : 3'b000;
      check($sformatf("requal_k%0d", k), ec, ep, 3'b000, k == 6);
    end
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b0, 3'b111);
      ec = (k < 6) ? 3'b110 : 3'b111;
      er = (k == 6) ? 3'b001 : 3'b000;
      check($sformatf("requal_rel_k%0d", k), ec, 3'b000, er, k == 6);
    end

    // Bounce 0,1,0,0,0,0 on channel 0: commit only after four consecutive synced zeros.
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, {2'b11, (k <= 6) ? pat[k-1] : 1'b0});
      ec = (k < 8) ? 3'b111 : 3'b110;
      ep = (k == 8) ? 3'b001 : 3'b000;
      check($sformatf("bounce_k%0d", k), ec, ep, 3'b000, k == 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
